spi_responder: RTL

//  Peripheral (responder) end of the board's register-access SPI link: receives a
//  REG_WIDTH-bit address then a data word, returns the addressed register's old

---
 rtl/spi_responder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// SPI register-access responder: address then data word in, old register value out LSB first, commit on cs_n rise.
// Defining SPI_RESPONDER_STATUS_REG_EN maps a read-only write-count/error status register at address NUM_REGS.
module spi_responder #(
  parameter int REG_WIDTH = 8,
  parameter int MSG_LEN   = 2,
  parameter int NUM_REGS  = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     spi_clk,
  input  logic                                     spi_cs_n,
  input  logic                                     spi_mosi,
  output logic                                     spi_miso,
  output logic [NUM_REGS*REG_WIDTH*(MSG_LEN-1)-1:0] reg_file,
  output logic                                     wr_strobe,
  output logic [REG_WIDTH-1:0]                     wr_addr,
  output logic                                     frame_error
);
  localparam int DATA_W = REG_WIDTH * (MSG_LEN - 1);
  localparam int CNT_W  = $clog2((DATA_W > REG_WIDTH) ? DATA_W : REG_WIDTH);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [REG_WIDTH:0] NREGS     = (REG_WIDTH+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(REG_WIDTH - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  // Pin synchronisers; cs_n resets high so a fresh reset never looks like a frame start.
  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, cs_s, mosi_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      cs_q   <= {cs_q[0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]   ash_q, ash_d;
  logic [REG_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]      dsh_q, dsh_d;
  logic [DATA_W-1:0]      rd_q, rd_d;
  logic                   miso_q, miso_d;
  logic                   adv_q, adv_d;
  logic                   stb_q, stb_d;
  logic [REG_WIDTH-1:0]   waddr_q, waddr_d;
  logic                   err_q, err_d;
  logic                   reg_we;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0]   addr_nxt;
  logic [DATA_W-1:0]      rd_val;
`ifdef SPI_RESPONDER_STATUS_REG_EN
  logic [DATA_W-2:0]      wcnt_q, wcnt_d;
`endif

  assign addr_nxt = {ash_q[REG_WIDTH-2:0], mosi_s};

  always_comb begin
    rd_val = '0;
    if ({1'b0, addr_nxt} < NREGS) begin
      rd_val = regs_q[addr_nxt[IDX_W-1:0]];
    end
`ifdef SPI_RESPONDER_STATUS_REG_EN
    else if ({1'b0, addr_nxt} == NREGS) begin
      rd_val = {wcnt_q, err_q};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ash_d   = ash_q;
    addr_d  = addr_q;
    dsh_d   = dsh_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    adv_d   = adv_q;
    stb_d   = 1'b0;
    waddr_d = waddr_q;
    err_d   = err_q;
    reg_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        adv_d  = 1'b0;
        if (!cs_s) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cs_s) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          ash_d = addr_nxt;
          if (cnt_q == ADDR_LAST) begin
            addr_d  = addr_nxt;
            rd_d    = rd_val;
            miso_d  = rd_val[0];
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (cs_s) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          dsh_d = {dsh_q[DATA_W-2:0], mosi_s};
          adv_d = 1'b1;
          if (cnt_q == DATA_LAST) begin
            miso_d  = 1'b0;
            adv_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && adv_q) begin
          // Initiator samples on rise, so the next read bit appears only after the fall.
          rd_d   = rd_q >> 1;
          miso_d = rd_q[1];
          adv_d  = 1'b0;
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (cs_s) begin
          state_d = S_IDLE;
          if ({1'b0, addr_q} < NREGS) begin
            reg_we  = 1'b1;
            stb_d   = 1'b1;
            waddr_d = addr_q;
          end
`ifdef SPI_RESPONDER_STATUS_REG_EN
          else if ({1'b0, addr_q} == NREGS) begin
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SPI_RESPONDER_STATUS_REG_EN
  always_comb begin
    wcnt_d = wcnt_q;
    if (reg_we) wcnt_d = wcnt_q + (DATA_W-1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ash_q   <= '0;
      addr_q  <= '0;
      dsh_q   <= '0;
      rd_q    <= '0;
      miso_q  <= 1'b0;
      adv_q   <= 1'b0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ash_q   <= ash_d;
      addr_q  <= addr_d;
      dsh_q   <= dsh_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      adv_q   <= adv_d;
      stb_q   <= stb_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[addr_q[IDX_W-1:0]] <= dsh_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_file[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign spi_miso    = miso_q;
  assign wr_strobe   = stb_q;
  assign wr_addr     = waddr_q;
  assign frame_error = err_q;
endmodule
